// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// UART_TX_BREAK_EN enables the BREAK state in uart_tx_cfg.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  localparam int BREAK_PULSES = 13;

  function automatic int frame_bits(
    input int      bpw,
    input parity_e par,
    input logic    stop2
  );
    return 1 + bpw + ((par != PAR_NONE) ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Stream-fed UART transmitter: W_OUT-bit beats sent as NUM_WORDS words.
// UART_TX_BREAK_EN adds brk_req and a line BREAK sequence.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int FIFO_DEPTH       = 4,
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_OUT-1:0] s_data,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic             brk_req,
`endif
  output logic             tx,
  output logic             busy,
  output logic [LW-1:0]    fifo_level
);

  localparam int BW = $clog2(CLOCKS_PER_PULSE);
  localparam int CW = 4;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  tx_state_e        state;
  logic [BW-1:0]    baud;
  logic [CW-1:0]    bitc;
  logic [WW-1:0]    wordc;
  logic [W_OUT-1:0] shreg;
  parity_e          par_q;
  parity_e          cfg_par;
  logic             stop2_q;
  logic             par_bit;
  logic             brk;
  logic             push;
  logic             pop;
  logic [W_OUT-1:0] dout;
  logic             full;
  logic             empty;
  logic [LW-1:0]    lvl_nxt;
  logic             bit_end;
  logic             stop_last;
  logic             word_last;
  logic             tx_d;

`ifdef UART_TX_BREAK_EN
  assign brk = brk_req;
`else
  assign brk = 1'b0;
`endif

  assign cfg_par   = (cfg_parity == 2'b11) ? PAR_NONE
                                           : parity_e'(cfg_parity);
  assign bit_end   = baud == BW'(CLOCKS_PER_PULSE - 1);
  assign stop_last = bitc == CW'(stop2_q);
  assign word_last = wordc == WW'(NUM_WORDS - 1);
  assign push      = s_valid && s_ready;
  assign pop       = !empty && !brk &&
                     (state == IDLE ||
                      (state == STOP && bit_end &&
                       stop_last && word_last));
  assign lvl_nxt   = fifo_level + LW'(push) - LW'(pop);
  assign busy      = (state != IDLE) || !empty;

  sync_fifo #(
    .WIDTH(W_OUT),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .pop  (pop),
    .din  (s_data),
    .dout (dout),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  // tx is the registered image of the state, one cycle behind it
  always_comb begin
    tx_d = 1'b1;
    unique case (state)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg[0];
      PARITY: tx_d = par_bit;
      STOP:   tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK:  tx_d = bitc >= CW'(BREAK_PULSES);
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bitc    <= '0;
      wordc   <= '0;
      shreg   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      s_ready <= 1'b0;
    end else begin
      s_ready <= lvl_nxt != LW'(FIFO_DEPTH);
      tx      <= tx_d;
      baud    <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
      if (pop) begin
        shreg   <= dout;
        par_q   <= cfg_par;
        stop2_q <= cfg_stop2;
      end
      unique case (state)
        IDLE: begin
          bitc  <= '0;
          wordc <= '0;
          if (brk)      state <= BREAK;
          else if (pop) state <= START;
        end
        START: if (bit_end) begin
          par_bit <= (^shreg[BITS_PER_WORD-1:0]) ^ (par_q == PAR_ODD);
          state   <= DATA;
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (bitc == CW'(BITS_PER_WORD - 1)) begin
            bitc  <= '0;
            state <= (par_q == PAR_NONE) ? STOP : PARITY;
          end else begin
            bitc <= bitc + CW'(1);
          end
        end
        PARITY: if (bit_end) state <= STOP;
        STOP: if (bit_end) begin
          if (!stop_last) begin
            bitc <= bitc + CW'(1);
          end else begin
            bitc <= '0;
            if (!word_last) begin
              wordc <= wordc + WW'(1);
              state <= START;
            end else begin
              wordc <= '0;
              if (brk)      state <= BREAK;
              else if (pop) state <= START;
              else          state <= IDLE;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: if (bit_end) begin
          if (bitc == CW'(BREAK_PULSES)) begin
            bitc  <= '0;
            state <= IDLE;
          end else begin
            bitc <= bitc + CW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomised self-checking bench for uart_tx_cfg; tx is decoded per bit
// period and compared with a frame model built from the beat values.
module tb_uart_tx_cfg;

  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int W     = 16;
  localparam int D     = 4;
  localparam int NW    = W / BPW;
  localparam int LIMIT = 2000;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic [1:0]   cfg_parity = 2'b00;
  logic         cfg_stop2 = 1'b0;
  logic         brk_req = 1'b0;
  logic         tx;
  logic         busy;
  logic [2:0]   fifo_level;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int refused  = 0;
  logic exp_q[$];
  logic got_q[$];

  uart_tx_cfg #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .W_OUT(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .cfg_parity(cfg_parity),
    .cfg_stop2 (cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .brk_req   (brk_req),
`endif
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected line bits, one entry per bit period
  task automatic add_beat(input logic [W-1:0] beat,
                          input logic [1:0] par, input logic st2);
    logic [BPW-1:0] word;
    for (int w = 0; w < NW; w++) begin
      word = beat[w*BPW +: BPW];
      exp_q.push_back(1'b0);
      for (int b = 0; b < BPW; b++) exp_q.push_back(word[b]);
      if (par == 2'b01) exp_q.push_back(^word);
      if (par == 2'b10) exp_q.push_back(~^word);
      exp_q.push_back(1'b1);
      if (st2) exp_q.push_back(1'b1);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < LIMIT) begin
      refused++;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_fall(output int k);
    k = 0;
    while (tx !== 1'b0 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
  endtask

  // One entry per bit period; x if tx was not stable across the period
  task automatic capture(input int n);
    logic v;
    logic same;
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      v = tx;
      same = 1'b1;
      for (int c = 0; c < CPP; c++) begin
        if (tx !== v) same = 1'b0;
        @(negedge clk);
      end
      got_q.push_back(same ? v : 1'bx);
    end
  endtask

  function automatic int diff_count();
    int n = 0;
    if (got_q.size() != exp_q.size()) return 9999;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({tx, s_ready, busy, fifo_level} !== {1'b1, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_vals got tx=%b rdy=%b busy=%b lvl=%0d want 1 0 0 0",
               tx, s_ready, busy, fifo_level);
    else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (s_ready !== 1'b1)
      $display("FAIL reset_release got s_ready=%b want 1", s_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int k;
    int d;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    exp_q.delete();
    add_beat(16'hA53C, 2'b00, 1'b0);
    push(16'hA53C);
    wait_fall(k);
    chk_cnt++;
    if (k !== 2) $display("FAIL basic_latency got %0d want 2", k);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy);
    else pass_cnt++;
    capture(20);
    d = diff_count();
    chk_cnt++;
    if (d !== 0) $display("FAIL basic_stream got %0d bad bits want 0", d);
    else pass_cnt++;
    chk_cnt++;
    if ({tx, busy, fifo_level} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL basic_idle got tx=%b busy=%b lvl=%0d want 1 0 0",
               tx, busy, fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    int k;
    int d;
    cfg_parity = 2'b01;
    exp_q.delete();
    add_beat(16'h0107, 2'b01, 1'b0);
    push(16'h0107);
    wait_fall(k);
    capture(22);
    d = diff_count();
    chk_cnt++;
    if (d !== 0 || got_q[9] !== 1'b1 || got_q[20] !== 1'b1)
      $display("FAIL parity_even got %0d bad bits p=%b%b want 0 p=11",
               d, got_q[9], got_q[20]);
    else pass_cnt++;
    for (int m = 1; m <= 2; m++) begin
      cfg_parity = 2'(m);
      exp_q.delete();
      add_beat(16'h003C, 2'(m), 1'b0);
      push(16'h003C);
      wait_fall(k);
      capture(22);
      chk_cnt++;
      if (got_q[9] !== (m == 2))
        $display("FAIL parity_3c mode=%0d got %b want %b",
                 m, got_q[9], m == 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_stop2_latch();
    int k;
    int d;
    logic [W-1:0] b = 16'($urandom());
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    exp_q.delete();
    add_beat(b, 2'b00, 1'b1);
    push(b);
    wait_fall(k);
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b0;
    capture(exp_q.size());
    d = diff_count();
    chk_cnt++;
    if (d !== 0) $display("FAIL stop2_stream got %0d bad bits want 0", d);
    else pass_cnt++;
    chk_cnt++;
    if ({got_q[9], got_q[10], got_q[11]} !== 3'b110)
      $display("FAIL stop2_gap got %b%b%b want 110",
               got_q[9], got_q[10], got_q[11]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int k;
    int d;
    logic [W-1:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 16'($urandom());
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      exp_q.delete();
      add_beat(b, cfg_parity, cfg_stop2);
      push(b);
      wait_fall(k);
      capture(exp_q.size());
      d = diff_count();
      chk_cnt++;
      if (k !== 2 || d !== 0)
        $display("FAIL random_%0d beat=%h got lat=%0d bad=%0d want 2 0",
                 i, b, k, d);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] beats [6];
    int k;
    int d;
    int maxlvl = 0;
    int seen_low = 0;
    bit done = 0;
    cfg_parity = 2'($urandom_range(0, 3));
    cfg_stop2  = 1'($urandom_range(0, 1));
    exp_q.delete();
    foreach (beats[i]) begin
      beats[i] = 16'($urandom());
      add_beat(beats[i], cfg_parity, cfg_stop2);
    end
    refused = 0;
    fork
      begin
        foreach (beats[i]) push(beats[i]);
        done = 1;
      end
      begin
        wait_fall(k);
        capture(exp_q.size());
      end
      begin
        while (!done) begin
          if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
          if (s_ready === 1'b0) seen_low = 1;
          @(negedge clk);
        end
      end
    join
    d = diff_count();
    chk_cnt++;
    if (d !== 0) $display("FAIL b2b_stream got %0d bad bits want 0", d);
    else pass_cnt++;
    chk_cnt++;
    if (maxlvl < 3 || maxlvl > 4)
      $display("FAIL b2b_peak got %0d want 3..4", maxlvl);
    else pass_cnt++;
    chk_cnt++;
    if (seen_low !== 1 || refused == 0)
      $display("FAIL b2b_backpressure got low=%0d refused=%0d want 1 >0",
               seen_low, refused);
    else pass_cnt++;
    chk_cnt++;
    if ({tx, busy} !== 2'b11 && {tx, busy} !== 2'b10)
      $display("FAIL b2b_end got tx=%b want 1", tx);
    else pass_cnt++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k;
    int d;
    logic [W-1:0] b;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    push(16'h00FF);
    wait_fall(k);
    push(16'h1234);
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (fifo_level !== 3'd1)
      $display("FAIL mid_queued got %0d want 1", fifo_level);
    else pass_cnt++;
    rstn = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({tx, fifo_level, s_ready, busy} !== {1'b1, 3'd0, 1'b0, 1'b0})
      $display("FAIL mid_reset got tx=%b lvl=%0d rdy=%b busy=%b want 1 0 0 0",
               tx, fifo_level, s_ready, busy);
    else pass_cnt++;
    rstn = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (s_ready !== 1'b1)
      $display("FAIL mid_release got s_ready=%b want 1", s_ready);
    else pass_cnt++;
    b = 16'($urandom());
    cfg_parity = 2'b10;
    exp_q.delete();
    add_beat(b, 2'b10, 1'b0);
    push(b);
    wait_fall(k);
    capture(exp_q.size());
    d = diff_count();
    chk_cnt++;
    if (k !== 2 || d !== 0 || tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_after got lat=%0d bad=%0d tx=%b busy=%b want 2 0 1 0",
               k, d, tx, busy);
    else pass_cnt++;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int k;
    int d;
    int n_low = 0;
    int n_high = 0;
    logic [W-1:0] b = 16'($urandom());
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    exp_q.delete();
    add_beat(b, 2'b00, 1'b0);
    s_data  = b;
    s_valid = 1'b1;
    brk_req = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    brk_req = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL brk_busy got %b want 1", busy);
    else pass_cnt++;
    while (tx === 1'b0 && n_low < 100) begin n_low++; @(negedge clk); end
    while (tx === 1'b1 && n_high < 100) begin n_high++; @(negedge clk); end
    chk_cnt++;
    if (n_low !== 52 || n_high < 4 || n_high > 5)
      $display("FAIL brk_shape got low=%0d high=%0d want 52 4..5",
               n_low, n_high);
    else pass_cnt++;
    wait_fall(k);
    capture(exp_q.size());
    d = diff_count();
    chk_cnt++;
    if (d !== 0) $display("FAIL brk_beat got %0d bad bits want 0", d);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2_latch();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor of the parity UART transmitter.
- Accepts W_OUT-bit beats on a valid/ready stream and buffers them in an internal FIFO.
- Serialises each beat as NUM_WORDS back-to-back UART words, LSB word first and LSB bit first.
- Parity mode and stop-bit count are selectable at runtime.
- Sits between on-chip stream producers and the board TX pin.

Parameters:
- CLOCKS_PER_PULSE, 4, clk cycles per UART bit (>=2; 20833 for 200 MHz/9600).
- BITS_PER_WORD, 8, data bits per UART word (5..9).
- W_OUT, 16, input beat width; must be a multiple of BITS_PER_WORD.
- FIFO_DEPTH, 4, beats buffered; power of two, >=2.
- NUM_WORDS, W_OUT/BITS_PER_WORD, derived; do not override.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, reset; one clock, synchronous, active-low.
- s_valid, in, 1, input beat valid.
- s_ready, out, 1, FIFO can accept a beat.
- s_data, in, W_OUT, input beat.
- cfg_parity, in, 2, 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- cfg_stop2, in, 1, 0 = one stop bit, 1 = two stop bits.
- tx, out, 1, serial line; idle high.
- busy, out, 1, high while a word is on the line or the FIFO is non-empty.
- fifo_level, out, $clog2(FIFO_DEPTH+1), beats held in the FIFO.

Behaviour:
- Reset values (rstn low at a clk edge): tx=1, s_ready=0, busy=0, fifo_level=0, FSM=IDLE, all counters 0.
- s_ready is registered. It rises on the first edge after rstn returns high. Afterwards it equals !full.
- Push on s_valid && s_ready.
- Pop when the FSM leaves IDLE. The popped beat is loaded into a shift register.
- cfg_parity and cfg_stop2 are latched at pop and apply to all NUM_WORDS words of that beat. Mid-beat cfg changes have no effect.
- Push into an empty FIFO while IDLE: tx falls exactly 2 clk edges after the push edge.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> START (next word of the beat, or next beat if the FIFO is non-empty) or IDLE.
- Every bit is held exactly CLOCKS_PER_PULSE cycles.
- STOP lasts 1 or 2 bit periods according to the latched cfg_stop2.
- No idle gap between words of a beat, or between beats when data is waiting.
- Parity bit: even = XOR of data bits; odd = inverted XOR.
- Frame length per word: 1 + BITS_PER_WORD + (parity?1:0) + (stop2?2:1) bit periods.
- FIFO full with simultaneous pop: push refused that cycle; s_ready rises the next cycle.
- FIFO empty at end of STOP: go to IDLE with tx=1.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_level updates on the edge after push/pop; simultaneous push and pop leaves it unchanged.
- Reset mid-frame: tx returns to 1 at that edge. The FIFO is flushed and the partial word is discarded.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input brk_req (1 bit).
- When brk_req is high in IDLE, or sampled at the end of STOP, the FSM enters BREAK.
- BREAK drives tx=0 for BREAK_PULSES bit periods (package constant, 13), then holds tx=1 for one bit period.
- After that it returns to IDLE, and FIFO service resumes.
- busy is high during BREAK.
- brk_req has priority over a pending pop.
- Undefined: no port, no BREAK state; behaviour is identical to the above.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum: PAR_NONE, PAR_EVEN, PAR_ODD.
  - tx_state_e enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - BREAK_PULSES.
  - a function computing frame bit count.
- Sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rstn, push, pop, din, dout, full, empty, level).
- The top-level FSM, baud counter, bit counter and word counter live in uart_tx_cfg.

Test Plan:
- Single beat 16'hA53C, cfg_parity=00, cfg_stop2=0, CLOCKS_PER_PULSE=4:
  - word 8'h3C then 8'hA5, LSB first, each start=0 and one stop=1.
  - tx falls 2 cycles after the push; total 80 cycles low-to-idle.
- Even parity with 8'h3C (4 ones) gives parity 0; odd parity gives 1.
  - Beat 16'h0107 with even parity: parity bits 1 then 1.
- cfg_stop2=1: tx stays high for 8 cycles between words.
  - Change cfg mid-beat: second word still uses the latched config.
- Push 5 beats back-to-back with FIFO_DEPTH=4:
  - s_ready drops after the 4th accepted push (one beat popped → fifo_level peaks at 3 or 4 per timing).
  - All beats are received in order, with no idle gap between frames.
- Assert rstn low during the DATA bit of word 0:
  - tx=1, fifo_level=0 and s_ready=0 at the reset edge.
  - s_ready=1 one cycle after release; the next beat transmits cleanly.
- With UART_TX_BREAK_EN, pulse brk_req while a beat is queued:
  - tx low for 52 cycles, then 4 cycles high.
  - The queued beat transmits afterwards.
